lookup_load_ctrl: RTL and testbench

Sequencer that brings up one BCP run on the lookup array. It streams per-engine dummy pointers and clause nodes from memory into the clause load buffer, stepping to the next engine with `change_eng` after each engine's block. It then injects the initial unit literals into the unit-clause arbiter, releases `halt` for a bounded run window, and drains the merged stack into a result stream. It sits between the memory-side loader and the lookup top, and owns `halt`, the load ports, the `mem2uca` ports and `mstack_pop`.

---
 rtl/lookup_load_ctrl_pkg.sv | 44 ++++
 rtl/lookup_load_ctrl_counter.sv | 34 +++
 rtl/lookup_load_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lookup_load_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_load_ctrl_pkg.sv
// rtl/lookup_load_ctrl_pkg.sv - shared types, load-word tag and sequencer state encoding
`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

package lookup_load_ctrl_pkg;

    localparam int LIT_W = 8;

    typedef logic [LIT_W-1:0] lit_t;

    typedef struct packed {
        lit_t lit_a;
        lit_t lit_b;
    } node_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] len;
    } dummy_entry_t;

    typedef enum logic {
        LW_NODE = 1'b0,
        LW_PTR  = 1'b1
    } load_word_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LD_PTR   = 4'd1,
        LD_CLS   = 4'd2,
        NEXT_ENG = 4'd3,
        UC_INJ   = 4'd4,
        UC_DONE  = 4'd5,
        RUN      = 4'd6,
        DRAIN    = 4'd7,
        FIN      = 4'd8
    } lctl_state_t;

    // Word type the load stream must carry while in a given load state.
    function automatic load_word_t expected_tag(input lctl_state_t st);
        return (st == LD_PTR) ? LW_PTR : LW_NODE;
    endfunction

endpackage

// File: rtl/lookup_load_ctrl_counter.sv
// rtl/lookup_load_ctrl_counter.sv - loadable down-counter that holds at zero and flags it
module lctl_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lookup_load_ctrl.sv
// rtl/lookup_load_ctrl.sv - BCP run sequencer: load engines, inject unit literals, run, drain stack
// Engine switching is built only with LOOKUP_MULTI_ENGINE_EN defined; otherwise one engine is loaded.
module lookup_load_ctrl
    import lookup_load_ctrl_pkg::*;
#(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_clause_cnt,
    input  logic [CNT_W-1:0] cfg_run_cycles,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             src_is_ptr,
    input  node_t            src_node,
    input  dummy_entry_t     src_ptr,
    output node_t            node_in,
    output logic             node_in_valid,
    output dummy_entry_t     dummy_ptr,
    output logic             dummy_ptr_valid,
    output logic             change_eng,
    input  logic             uc_valid,
    output logic             uc_ready,
    input  lit_t             uc_lit,
    input  logic             uc_last,
    output lit_t             mem2uca,
    output logic             mem2uca_valid,
    output logic             mem2uca_done,
    output logic             halt,
    input  logic             conflict,
    input  logic             mstack_empty,
    input  lit_t             mstack_lit,
    output logic             mstack_pop,
    output lit_t             res_lit,
    output logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             conflict_flag,
    output logic             err
);

`ifdef LOOKUP_MULTI_ENGINE_EN
    localparam bit MULTI_ENG = 1'b1;
`else
    localparam bit MULTI_ENG = 1'b0;
`endif
    localparam logic [7:0] ENG_LAST = MULTI_ENG ? 8'(NUM_ENGINE - 1) : 8'd0;

    lctl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cfg_cls_q, cfg_run_q;
    logic [7:0]       eng_idx_q, eng_idx_d;
    node_t            node_in_q;
    dummy_entry_t     dummy_ptr_q;
    lit_t             mem2uca_q, res_lit_q;
    logic             node_in_valid_q, dummy_ptr_valid_q, mem2uca_valid_q, res_valid_q;
    logic             err_q, conflict_flag_q;

    logic             src_acc, uc_acc, word_ok, more_eng;
    logic             cls_load, cls_dec, cls_zero, run_load, run_dec, run_zero;
    logic [CNT_W-1:0] cls_load_val, run_load_val;

    assign src_acc  = src_valid && src_ready;
    assign uc_acc   = uc_valid && uc_ready;
    assign word_ok  = (load_word_t'(src_is_ptr) == expected_tag(state_q));
    assign more_eng = (eng_idx_q < ENG_LAST);

    // Counters are loaded with N-1 so the zero flag marks the final beat/cycle.
    assign cls_load     = (state_q == LD_PTR) && src_acc;
    assign cls_load_val = cfg_cls_q - CNT_W'(1);
    assign cls_dec      = (state_q == LD_CLS) && src_acc;
    assign run_load     = (state_q == UC_DONE);
    assign run_load_val = (cfg_run_q == '0) ? '0 : cfg_run_q - CNT_W'(1);
    assign run_dec      = (state_q == RUN);

    lctl_counter #(.W(CNT_W)) u_cls_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cls_load),
        .load_val_i (cls_load_val),
        .dec_i      (cls_dec),
        .zero_o     (cls_zero)
    );

    lctl_counter #(.W(CNT_W)) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run_load),
        .load_val_i (run_load_val),
        .dec_i      (run_dec),
        .zero_o     (run_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = LD_PTR;
            LD_PTR:   if (src_acc) state_d = (cfg_cls_q == '0) ? NEXT_ENG : LD_CLS;
            LD_CLS:   if (src_acc && cls_zero) state_d = NEXT_ENG;
            NEXT_ENG: state_d = more_eng ? LD_PTR : UC_INJ;
            UC_INJ:   if (uc_acc && uc_last) state_d = UC_DONE;
            UC_DONE:  state_d = RUN;
            // Conflict takes priority over the window expiring in the same cycle.
            RUN: begin
                if (conflict) state_d = FIN;
                else if (run_zero) state_d = DRAIN;
            end
            DRAIN:    if (conflict || mstack_empty) state_d = FIN;
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        src_ready    = 1'b0;
        uc_ready     = 1'b0;
        mstack_pop   = 1'b0;
        halt         = 1'b1;
        done         = 1'b0;
        mem2uca_done = 1'b0;
        change_eng   = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            LD_PTR, LD_CLS: src_ready = 1'b1;
            NEXT_ENG: begin
`ifdef LOOKUP_MULTI_ENGINE_EN
                change_eng = more_eng;
`endif
            end
            UC_INJ:   uc_ready     = 1'b1;
            UC_DONE:  mem2uca_done = 1'b1;
            RUN:      halt         = 1'b0;
            DRAIN:    mstack_pop   = !mstack_empty;
            FIN:      done         = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        eng_idx_d = eng_idx_q;
        if (state_q == IDLE && start) begin
            eng_idx_d = 8'd0;
        end else if (state_q == NEXT_ENG && more_eng) begin
            eng_idx_d = eng_idx_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_idx_q         <= 8'd0;
            cfg_cls_q         <= '0;
            cfg_run_q         <= '0;
            node_in_q         <= '0;
            node_in_valid_q   <= 1'b0;
            dummy_ptr_q       <= '0;
            dummy_ptr_valid_q <= 1'b0;
            mem2uca_q         <= '0;
            mem2uca_valid_q   <= 1'b0;
            res_lit_q         <= '0;
            res_valid_q       <= 1'b0;
            err_q             <= 1'b0;
            conflict_flag_q   <= 1'b0;
        end else begin
            eng_idx_q         <= eng_idx_d;
            node_in_valid_q   <= 1'b0;
            dummy_ptr_valid_q <= 1'b0;
            mem2uca_valid_q   <= 1'b0;
            res_valid_q       <= 1'b0;
            if (state_q == IDLE && start) begin
                cfg_cls_q       <= cfg_clause_cnt;
                cfg_run_q       <= cfg_run_cycles;
                err_q           <= 1'b0;
                conflict_flag_q <= 1'b0;
            end
            // A mistyped word is swallowed so the stream keeps its position.
            if (src_acc && !word_ok) begin
                err_q <= 1'b1;
            end
            if (src_acc && word_ok) begin
                if (state_q == LD_PTR) begin
                    dummy_ptr_q       <= src_ptr;
                    dummy_ptr_valid_q <= 1'b1;
                end else begin
                    node_in_q       <= src_node;
                    node_in_valid_q <= 1'b1;
                end
            end
            if (uc_acc) begin
                mem2uca_q       <= uc_lit;
                mem2uca_valid_q <= 1'b1;
            end
            if (mstack_pop) begin
                res_lit_q   <= mstack_lit;
                res_valid_q <= 1'b1;
            end
            if ((state_q == RUN || state_q == DRAIN) && conflict) begin
                conflict_flag_q <= 1'b1;
            end
        end
    end

    assign node_in         = node_in_q;
    assign node_in_valid   = node_in_valid_q;
    assign dummy_ptr       = dummy_ptr_q;
    assign dummy_ptr_valid = dummy_ptr_valid_q;
    assign mem2uca         = mem2uca_q;
    assign mem2uca_valid   = mem2uca_valid_q;
    assign res_lit         = res_lit_q;
    assign res_valid       = res_valid_q;
    assign err             = err_q;
    assign conflict_flag   = conflict_flag_q;

endmodule

// File: tb/tb_lookup_load_ctrl.sv
// tb/tb_lookup_load_ctrl.sv - directed self-checking bench for lookup_load_ctrl
module tb_lookup_load_ctrl;
    import lookup_load_ctrl_pkg::*;

    localparam int NE = 2;
`ifdef LOOKUP_MULTI_ENGINE_EN
    localparam int E = NE;
`else
    localparam int E = 1;
`endif

    logic         clk, rst, start;
    logic [15:0]  cfg_clause_cnt, cfg_run_cycles;
    logic         src_valid, src_ready, src_is_ptr;
    node_t        src_node, node_in;
    dummy_entry_t src_ptr, dummy_ptr;
    logic         node_in_valid, dummy_ptr_valid, change_eng;
    logic         uc_valid, uc_ready, uc_last;
    lit_t         uc_lit, mem2uca, mstack_lit, res_lit;
    logic         mem2uca_valid, mem2uca_done, halt, conflict;
    logic         mstack_empty, mstack_pop, res_valid;
    logic         busy, done, conflict_flag, err;

    lookup_load_ctrl #(.NUM_ENGINE(NE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_clause_cnt(cfg_clause_cnt), .cfg_run_cycles(cfg_run_cycles),
        .src_valid(src_valid), .src_ready(src_ready), .src_is_ptr(src_is_ptr),
        .src_node(src_node), .src_ptr(src_ptr),
        .node_in(node_in), .node_in_valid(node_in_valid),
        .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng),
        .uc_valid(uc_valid), .uc_ready(uc_ready), .uc_lit(uc_lit), .uc_last(uc_last),
        .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done),
        .halt(halt), .conflict(conflict),
        .mstack_empty(mstack_empty), .mstack_lit(mstack_lit), .mstack_pop(mstack_pop),
        .res_lit(res_lit), .res_valid(res_valid),
        .busy(busy), .done(done), .conflict_flag(conflict_flag), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int c_dptr, c_node, c_chg, c_m2u, c_m2u_done, c_res, c_done, c_pop, c_halt_lo, c_acc, chg_at;
    logic [15:0] last_node, last_ptr;
    lit_t res_q[$];
    lit_t m2u_q[$];

    logic        w_ptr [16];
    logic [15:0] w_dat [16];
    lit_t        u_lit [8];

    always @(negedge clk) begin
        if (src_valid && src_ready) c_acc++;
        if (dummy_ptr_valid) begin c_dptr++; last_ptr = dummy_ptr; end
        if (node_in_valid) begin c_node++; last_node = node_in; end
        if (change_eng) begin
            c_chg++;
            if (chg_at < 0) chg_at = c_acc;
        end
        if (mem2uca_valid) begin c_m2u++; m2u_q.push_back(mem2uca); end
        if (mem2uca_done) c_m2u_done++;
        if (res_valid) begin c_res++; res_q.push_back(res_lit); end
        if (done) c_done++;
        if (mstack_pop) c_pop++;
        if (!halt) c_halt_lo++;
    end

    // Merged-stack model: pops take effect just after the edge that saw mstack_pop.
    lit_t stk[$];
    logic pop_now = 1'b0;
    always @(negedge clk) pop_now = mstack_pop;
    always @(posedge clk) begin
        #1;
        if (pop_now && stk.size() > 0) void'(stk.pop_back());
        mstack_empty = (stk.size() == 0);
        mstack_lit   = (stk.size() > 0) ? stk[$] : '0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        c_dptr = 0; c_node = 0; c_chg = 0; c_m2u = 0; c_m2u_done = 0; c_res = 0;
        c_done = 0; c_pop = 0; c_halt_lo = 0; c_acc = 0; chg_at = -1;
        last_node = '0; last_ptr = '0;
        res_q.delete();
        m2u_q.delete();
    endtask

    task automatic do_start(input logic [15:0] cls, input logic [15:0] run);
        cfg_clause_cnt = cls;
        cfg_run_cycles = run;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed_src(input int n, input int bubble_at);
        int i = 0;
        int guard = 0;
        logic rdy;
        logic bubbled = 1'b0;
        while (i < n && guard < 200) begin
            guard++;
            if (i == bubble_at && !bubbled) begin
                bubbled = 1'b1;
                src_valid = 1'b0;
                step();
            end else begin
                src_valid  = 1'b1;
                src_is_ptr = w_ptr[i];
                src_node   = node_t'(w_dat[i]);
                src_ptr    = dummy_entry_t'(w_dat[i]);
                rdy = src_ready;
                step();
                if (rdy) i++;
            end
        end
        src_valid = 1'b0;
        if (i < n) begin
            n_tests++; n_fail++;
            $display("FAIL feed_src timeout: accepted %0d words, required %0d", i, n);
        end
    endtask

    task automatic feed_uc(input int n);
        int i = 0;
        int guard = 0;
        logic rdy;
        while (i < n && guard < 200) begin
            guard++;
            uc_valid = 1'b1;
            uc_lit   = u_lit[i];
            uc_last  = (i == n - 1);
            rdy = uc_ready;
            step();
            if (rdy) i++;
        end
        uc_valid = 1'b0;
        uc_last  = 1'b0;
        if (i < n) begin
            n_tests++; n_fail++;
            $display("FAIL feed_uc timeout: accepted %0d literals, required %0d", i, n);
        end
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        int d0 = c_done;
        while (c_done == d0 && k < limit) begin
            step();
            k++;
        end
        n_tests++;
        if (c_done == d0) begin
            n_fail++;
            $display("FAIL wait_done: no done pulse within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_tests++;
        if ({halt, busy, src_ready, uc_ready, mstack_pop, node_in_valid, dummy_ptr_valid, change_eng,
             mem2uca_valid, mem2uca_done, res_valid, done, conflict_flag, err} !== 14'b1000_0000_0000_00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required %b",
                {halt, busy, src_ready, uc_ready, mstack_pop, node_in_valid, dummy_ptr_valid, change_eng,
                 mem2uca_valid, mem2uca_done, res_valid, done, conflict_flag, err}, 14'b1000_0000_0000_00);
        end
        n_tests++;
        if ({node_in, dummy_ptr, mem2uca, res_lit} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {node_in, dummy_ptr, mem2uca, res_lit});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_and_run();
        logic [31:0] got;
        clear_counts();
        stk.push_back(8'h11); stk.push_back(8'h22); stk.push_back(8'h33); stk.push_back(8'h44);
        for (int e = 0; e < E; e++) begin
            w_ptr[4*e] = 1'b1;
            w_dat[4*e] = 16'hA000 + 16'(e);
            for (int j = 1; j < 4; j++) begin
                w_ptr[4*e+j] = 1'b0;
                w_dat[4*e+j] = 16'hB000 + 16'(e*16) + 16'(j-1);
            end
        end
        do_start(16'd3, 16'd5);
        feed_src(4*E, 2);
        step();
        n_tests++;
        if (c_dptr !== E) begin n_fail++; $display("FAIL load_ptr_count: got %0d required %0d", c_dptr, E); end
        n_tests++;
        if (c_node !== 3*E) begin n_fail++; $display("FAIL load_node_count: got %0d required %0d", c_node, 3*E); end
        n_tests++;
        if (c_chg !== E-1) begin n_fail++; $display("FAIL load_change_eng: got %0d required %0d", c_chg, E-1); end
        n_tests++;
        if (last_node !== 16'hB000 + 16'((E-1)*16) + 16'd2) begin
            n_fail++; $display("FAIL load_last_node: got %h required %h", last_node, 16'hB000 + 16'((E-1)*16) + 16'd2);
        end
`ifdef LOOKUP_MULTI_ENGINE_EN
        n_tests++;
        if (chg_at !== 4) begin n_fail++; $display("FAIL load_change_pos: got %0d required 4", chg_at); end
`endif
        n_tests++;
        if ({err, uc_ready, halt, busy} !== 4'b0111) begin
            n_fail++; $display("FAIL load_end_state: got %b required 0111", {err, uc_ready, halt, busy});
        end
        // start while busy must not relatch the run window
        cfg_run_cycles = 16'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        u_lit[0] = 8'h05; u_lit[1] = 8'h0A; u_lit[2] = 8'h0F;
        feed_uc(3);
        step();
        got = '0;
        foreach (m2u_q[i]) got = {got[23:0], m2u_q[i]};
        n_tests++;
        if (c_m2u !== 3 || got[23:0] !== 24'h050A0F) begin
            n_fail++; $display("FAIL uc_forward: got %0d beats %h required 3 beats 050a0f", c_m2u, got[23:0]);
        end
        n_tests++;
        if (c_m2u_done !== 1 || halt !== 1'b0) begin
            n_fail++; $display("FAIL uc_done_then_run: got done=%0d halt=%b required done=1 halt=0", c_m2u_done, halt);
        end
        wait_done(100);
        n_tests++;
        if (c_halt_lo !== 5) begin n_fail++; $display("FAIL run_window: got %0d required 5", c_halt_lo); end
        got = '0;
        foreach (res_q[i]) got = {got[23:0], res_q[i]};
        n_tests++;
        if (c_res !== 4 || got !== 32'h44332211) begin
            n_fail++; $display("FAIL drain_lifo: got %0d beats %h required 4 beats 44332211", c_res, got);
        end
        n_tests++;
        if ({c_done == 1, conflict_flag, busy, halt} !== 4'b1001) begin
            n_fail++; $display("FAIL run_finish: got done_cnt=%0d flag=%b busy=%b halt=%b required 1 0 0 1",
                c_done, conflict_flag, busy, halt);
        end
    endtask

    task automatic test_zero_clause();
        clear_counts();
        for (int e = 0; e < E; e++) begin
            w_ptr[e] = 1'b1;
            w_dat[e] = 16'hC000 + 16'(e);
        end
        do_start(16'd0, 16'd0);
        feed_src(E, -1);
        step();
        n_tests++;
        if (c_dptr !== E || c_node !== 0) begin
            n_fail++; $display("FAIL zero_cls_counts: got ptr=%0d node=%0d required ptr=%0d node=0", c_dptr, c_node, E);
        end
        n_tests++;
        if (c_chg !== E-1) begin n_fail++; $display("FAIL zero_cls_change_eng: got %0d required %0d", c_chg, E-1); end
        n_tests++;
        if (last_ptr !== 16'hC000 + 16'(E-1)) begin
            n_fail++; $display("FAIL zero_cls_last_ptr: got %h required %h", last_ptr, 16'hC000 + 16'(E-1));
        end
`ifdef LOOKUP_MULTI_ENGINE_EN
        n_tests++;
        if (chg_at !== 1) begin n_fail++; $display("FAIL zero_cls_change_pos: got %0d required 1", chg_at); end
`endif
        u_lit[0] = 8'h77;
        feed_uc(1);
        wait_done(50);
        n_tests++;
        if (c_halt_lo !== 1 || c_res !== 0 || c_m2u !== 1) begin
            n_fail++; $display("FAIL zero_run_window: got halt_lo=%0d res=%0d m2u=%0d required 1 0 1", c_halt_lo, c_res, c_m2u);
        end
    endtask

    task automatic test_conflict();
        clear_counts();
        stk.push_back(8'h5A); stk.push_back(8'h6B);
        for (int e = 0; e < E; e++) begin
            w_ptr[2*e] = 1'b1;   w_dat[2*e]   = 16'hE000 + 16'(e);
            w_ptr[2*e+1] = 1'b0; w_dat[2*e+1] = 16'hE100 + 16'(e);
        end
        do_start(16'd1, 16'd5);
        feed_src(2*E, -1);
        step();
        u_lit[0] = 8'h21;
        feed_uc(1);
        step();
        step();
        conflict = 1'b1;
        step();
        conflict = 1'b0;
        wait_done(20);
        n_tests++;
        if (c_pop !== 0 || c_res !== 0) begin
            n_fail++; $display("FAIL conflict_no_drain: got pop=%0d res=%0d required 0 0", c_pop, c_res);
        end
        n_tests++;
        if (conflict_flag !== 1'b1 || c_done !== 1) begin
            n_fail++; $display("FAIL conflict_flag: got flag=%b done_cnt=%0d required 1 1", conflict_flag, c_done);
        end
        n_tests++;
        if (c_halt_lo !== 2) begin n_fail++; $display("FAIL conflict_run_len: got %0d required 2", c_halt_lo); end
        stk.delete();
        step();
    endtask

    task automatic test_type_err();
        clear_counts();
        for (int e = 0; e < E; e++) begin
            w_ptr[4*e] = (e != 0);
            w_dat[4*e] = (e == 0) ? 16'hDEAD : 16'hF100;
            for (int j = 1; j < 4; j++) begin
                w_ptr[4*e+j] = 1'b0;
                w_dat[4*e+j] = 16'hD000 + 16'(e*16) + 16'(j);
            end
        end
        do_start(16'd3, 16'd0);
        feed_src(4*E, -1);
        step();
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL type_err_flag: got %b required 1", err); end
        n_tests++;
        if (c_dptr !== E-1 || c_node !== 3*E) begin
            n_fail++; $display("FAIL type_err_counts: got ptr=%0d node=%0d required ptr=%0d node=%0d", c_dptr, c_node, E-1, 3*E);
        end
        n_tests++;
        if (c_chg !== E-1 || uc_ready !== 1'b1) begin
            n_fail++; $display("FAIL type_err_complete: got chg=%0d uc_ready=%b required %0d 1", c_chg, uc_ready, E-1);
        end
`ifdef LOOKUP_MULTI_ENGINE_EN
        n_tests++;
        if (chg_at !== 4) begin n_fail++; $display("FAIL type_err_change_pos: got %0d required 4", chg_at); end
`endif
        u_lit[0] = 8'h33;
        feed_uc(1);
        wait_done(50);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL type_err_sticky: got %b required 1", err); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        w_ptr[0] = 1'b1; w_dat[0] = 16'hF000;
        w_ptr[1] = 1'b0; w_dat[1] = 16'hF001;
        do_start(16'd3, 16'd5);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL start_clears_err: got %b required 0", err); end
        feed_src(2, -1);
        n_tests++;
        if ({busy, src_ready, node_in_valid, halt} !== 4'b1111) begin
            n_fail++; $display("FAIL mid_ld_cls: got %b required 1111", {busy, src_ready, node_in_valid, halt});
        end
        rst = 1'b1;
        step();
        n_tests++;
        if ({halt, busy, src_ready, uc_ready, mstack_pop, node_in_valid, dummy_ptr_valid, change_eng,
             mem2uca_valid, mem2uca_done, res_valid, done, conflict_flag, err} !== 14'b1000_0000_0000_00) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got %b required %b",
                {halt, busy, src_ready, uc_ready, mstack_pop, node_in_valid, dummy_ptr_valid, change_eng,
                 mem2uca_valid, mem2uca_done, res_valid, done, conflict_flag, err}, 14'b1000_0000_0000_00);
        end
        n_tests++;
        if ({node_in, dummy_ptr, mem2uca, res_lit} !== 48'h0) begin
            n_fail++; $display("FAIL reset_mid_data: got %h required 0", {node_in, dummy_ptr, mem2uca, res_lit});
        end
        rst = 1'b0;
        step(); step();
        n_tests++;
        if (c_done !== 0 || c_chg !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_abandon: got done=%0d chg=%0d busy=%b required 0 0 0", c_done, c_chg, busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_clause_cnt = '0; cfg_run_cycles = '0;
        src_valid = 1'b0; src_is_ptr = 1'b0; src_node = '0; src_ptr = '0;
        uc_valid = 1'b0; uc_lit = '0; uc_last = 1'b0;
        conflict = 1'b0; mstack_empty = 1'b1; mstack_lit = '0;
        clear_counts();
        test_reset();
        test_load_and_run();
        test_zero_clause();
        test_conflict();
        test_type_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
